// File: rtl/regfile_pkg.sv
// Register-file constants shared by regfile_sb and regfile_scoreboard:
// default sizes, the zero word and the enable encodings.
package regfile_pkg;

   localparam int REG_NUM_LOG2 = 5;
   localparam int REG_NUM      = 1 << REG_NUM_LOG2;
   localparam int REG_DATA_W   = 32;

   localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

   localparam logic WE_ON  = 1'b1;
   localparam logic WE_OFF = 1'b0;
   localparam logic RE_ON  = 1'b1;
   localparam logic RE_OFF = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard, one flop per register (r0 is never busy).
// Ports: clk, rst (async, active-low), we/waddr (writeback clears), rsv_en/rsv_addr (issue
// sets), flush (clears all), busy (busy vector). Priority: flush > reserve > writeback clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_NUM_LOG2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic                     flush,
   output logic [(1<<ADDR_W)-1:0]   busy
);

   localparam int NREG = 1 << ADDR_W;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_nxt;

   // Clears are applied first so a same-cycle reservation overrides them.
   always_comb begin
      busy_nxt = busy_q;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WE_ON)
               busy_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
         end
         if (rsv_en)
            busy_nxt[rsv_addr] = 1'b1;
         busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_nxt;
   end

   assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with scoreboard: NUM_WR sync write ports, NUM_RD comb read ports.
// Ports: clk, rst (async active-low), we/waddr/wdata, re/raddr/rdata/rbusy, rsv_en/rsv_addr,
// flush. Macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_NUM_LOG2,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic                     flush
);

   localparam int NREG = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] ZW = DATA_W'(ZERO_WORD);

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .flush    (flush),
      .busy     (busy)
   );

   // Ports are visited in ascending order, so the last NBA (highest port) wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++)
            regs[r] <= ZW;
      end else begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WE_ON && waddr[i*ADDR_W +: ADDR_W] != '0)
               regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         if (rst && re[j] == RE_ON) begin
            rdata[j*DATA_W +: DATA_W] = regs[raddr[j*ADDR_W +: ADDR_W]];
            rbusy[j] = busy[raddr[j*ADDR_W +: ADDR_W]] &&
                       (raddr[j*ADDR_W +: ADDR_W] != '0);
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NUM_WR; i++) begin
               if (we[i] == WE_ON &&
                   waddr[i*ADDR_W +: ADDR_W] != '0 &&
                   waddr[i*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]) begin
                  rdata[j*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                  rbusy[j] = 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (2 read, 2 write ports, 32 x 32-bit).
// Honours REGFILE_BYPASS_EN for the same-cycle read/write case.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        flush;

   int cmp;
   int bad;

   regfile_sb dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re       (re),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .flush    (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      we = 2'b00;
      rsv_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle();
      waddr = '0;
      wdata = '0;
      rsv_addr = '0;
      re = 2'b11;
      raddr = {5'd0, 5'd0};
      #2;
      cmp++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
         bad++;
         $display("FAIL in_reset: rdata=%h rbusy=%b want 0/0", rdata, rbusy);
      end
      #10 rst = 1'b1;
      tick();
      for (int r = 0; r < 32; r++) begin
         raddr = {5'(r), 5'(r)};
         #1;
         cmp++;
         if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            bad++;
            $display("FAIL reset_r%0d: rdata=%h rbusy=%b want 0/0", r, rdata, rbusy);
         end
      end
   endtask

   task automatic test_write;
      we = 2'b01;
      waddr = {5'd0, 5'd5};
      wdata = {32'h0, 32'hDEADBEEF};
      tick();
      idle();
      re = 2'b11;
      raddr = {5'd5, 5'd5};
      #1;
      cmp++;
      if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL write_r5: rdata=%h want deadbeef on both", rdata);
      end
      re = 2'b10;
      #1;
      cmp++;
      if (rdata[31:0] !== 32'h0) begin
         bad++;
         $display("FAIL re_off: rdata0=%h want 0", rdata[31:0]);
      end
      re = 2'b11;
      we = 2'b01;
      waddr = {5'd0, 5'd0};
      wdata = {32'h0, 32'h1};
      tick();
      idle();
      raddr = {5'd0, 5'd0};
      #1;
      cmp++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
         bad++;
         $display("FAIL write_r0: rdata=%h rbusy=%b want 0/0", rdata, rbusy);
      end
   endtask

   task automatic test_priority;
      we = 2'b11;
      waddr = {5'd7, 5'd7};
      wdata = {32'h22, 32'h11};
      tick();
      idle();
      raddr = {5'd7, 5'd7};
      #1;
      cmp++;
      if (rdata[31:0] !== 32'h22 || rdata[63:32] !== 32'h22) begin
         bad++;
         $display("FAIL wr_priority: rdata=%h want 22 on both", rdata);
      end
   endtask

   task automatic test_scoreboard;
      rsv_en = 1'b1;
      rsv_addr = 5'd3;
      tick();
      idle();
      raddr = {5'd5, 5'd3};
      #1;
      cmp++;
      if (rbusy !== 2'b01) begin
         bad++;
         $display("FAIL rsv_r3: rbusy=%b want 01", rbusy);
      end
      we = 2'b01;
      waddr = {5'd0, 5'd3};
      wdata = {32'h0, 32'h55};
      tick();
      idle();
      #1;
      cmp++;
      if (rbusy !== 2'b00 || rdata[31:0] !== 32'h55) begin
         bad++;
         $display("FAIL wb_r3: rbusy=%b rdata0=%h want 00/55", rbusy, rdata[31:0]);
      end
      rsv_en = 1'b1;
      rsv_addr = 5'd3;
      we = 2'b10;
      waddr = {5'd3, 5'd0};
      wdata = {32'h66, 32'h0};
      tick();
      idle();
      #1;
      cmp++;
      if (rbusy !== 2'b01 || rdata[31:0] !== 32'h66) begin
         bad++;
         $display("FAIL rsv_wb_r3: rbusy=%b rdata0=%h want 01/66", rbusy, rdata[31:0]);
      end
      rsv_en = 1'b1;
      rsv_addr = 5'd0;
      tick();
      idle();
      raddr = {5'd3, 5'd0};
      #1;
      cmp++;
      if (rbusy !== 2'b10) begin
         bad++;
         $display("FAIL rsv_r0: rbusy=%b want 10", rbusy);
      end
   endtask

   task automatic test_flush;
      rsv_en = 1'b1;
      rsv_addr = 5'd4;
      tick();
      rsv_addr = 5'd9;
      tick();
      idle();
      raddr = {5'd9, 5'd4};
      #1;
      cmp++;
      if (rbusy !== 2'b11) begin
         bad++;
         $display("FAIL rsv_r4_r9: rbusy=%b want 11", rbusy);
      end
      flush = 1'b1;
      rsv_en = 1'b1;
      rsv_addr = 5'd4;
      tick();
      idle();
      #1;
      cmp++;
      if (rbusy !== 2'b00) begin
         bad++;
         $display("FAIL flush: rbusy=%b want 00", rbusy);
      end
      rsv_en = 1'b1;
      rsv_addr = 5'd9;
      tick();
      idle();
      raddr = {5'd3, 5'd5};
      #3 rst = 1'b0;
      #1;
      cmp++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
         bad++;
         $display("FAIL async_rst: rdata=%h rbusy=%b want 0/0", rdata, rbusy);
      end
      #2 rst = 1'b1;
      raddr = {5'd9, 5'd5};
      #1;
      cmp++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
         bad++;
         $display("FAIL post_rst: rdata=%h rbusy=%b want 0/0", rdata, rbusy);
      end
   endtask

   task automatic test_bypass;
      logic [31:0] exp_now;
      we = 2'b01;
      waddr = {5'd0, 5'd12};
      wdata = {32'h0, 32'h1234};
      tick();
      we = 2'b10;
      waddr = {5'd12, 5'd0};
      wdata = {32'hA5A5, 32'h0};
      raddr = {5'd12, 5'd12};
`ifdef REGFILE_BYPASS_EN
      exp_now = 32'hA5A5;
`else
      exp_now = 32'h1234;
`endif
      #1;
      cmp++;
      if (rdata[31:0] !== exp_now) begin
         bad++;
         $display("FAIL same_cycle_r12: rdata0=%h want %h", rdata[31:0], exp_now);
      end
      tick();
      idle();
      #1;
      cmp++;
      if (rdata[63:32] !== 32'hA5A5) begin
         bad++;
         $display("FAIL next_cycle_r12: rdata1=%h want a5a5", rdata[63:32]);
      end
   endtask

   initial begin
      cmp = 0;
      bad = 0;
      test_reset();
      test_write();
      test_priority();
      test_scoreboard();
      test_flush();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
